// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect request and IF/ID handshake.
interface fetch_stage_if #(
  parameter int unsigned PC_WIDTH = 8
);

  logic [PC_WIDTH-1:0] IMEM_PC;
  logic [31:0]         IMEM_instruction;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                IF_ready;
  logic                IF_valid;
  logic [31:0]         IF_instruction;
  logic [PC_WIDTH-1:0] IF_PC;
  logic [PC_WIDTH-1:0] IF_PC_plus4;
  logic                halted;
  logic [15:0]         fetch_count;

  // Fetch stage side
  modport master (
    output IMEM_PC,
    input  IMEM_instruction,
    input  redirect_valid,
    input  redirect_target,
    input  IF_ready,
    output IF_valid,
    output IF_instruction,
    output IF_PC,
    output IF_PC_plus4,
    output halted,
    output fetch_count
  );

  // Memory / decode / redirect-source side
  modport slave (
    input  IMEM_PC,
    output IMEM_instruction,
    output redirect_valid,
    output redirect_target,
    output IF_ready,
    input  IF_valid,
    input  IF_instruction,
    input  IF_PC,
    input  IF_PC_plus4,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register and stops on a halt word.
module fetch_stage #(
  parameter int unsigned          PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [31:0]          NOP_WORD  = 32'h0000_0000,
  parameter logic [31:0]          HALT_WORD = 32'hFFFF_FFFF
) (
  input logic            clk,
  input logic            rst,
  fetch_stage_if.master  bus
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0]  ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0]  PC_STEP    = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next_seq;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                advance;
  logic                is_halt_word;

  // Memory address is the live PC; the memory answers in the same cycle
  assign bus.IMEM_PC = pc;

  // Sequential successor wraps naturally at the top of the address space
  assign pc_next_seq = pc + PC_STEP;

  // Redirect targets are forced word-aligned
  assign redirect_pc = bus.redirect_target & ALIGN_MASK;

  // A new word may be captured when running and the IF/ID slot is free or draining
  assign advance      = (state == RUN) && (!bus.IF_valid || bus.IF_ready);
  assign is_halt_word = (bus.IMEM_instruction == HALT_WORD);

  // Fetch FSM, PC and IF/ID register; redirect beats halt beats normal fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= RUN;
      pc                 <= RESET_PC & ALIGN_MASK;
      bus.IF_valid       <= 1'b0;
      bus.IF_instruction <= NOP_WORD;
      bus.IF_PC          <= '0;
      bus.IF_PC_plus4    <= '0;
      bus.halted         <= 1'b0;
      bus.fetch_count    <= '0;
    end else if (bus.redirect_valid) begin
      // Squash whatever sits in IF/ID, even if decode is stalling it
      state              <= RUN;
      pc                 <= redirect_pc;
      bus.IF_valid       <= 1'b0;
      bus.IF_instruction <= NOP_WORD;
      bus.halted         <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (advance) begin
            if (is_halt_word) begin
              // Halt word is consumed here and never forwarded; PC stays on it
              state              <= HALT;
              bus.halted         <= 1'b1;
              bus.IF_valid       <= 1'b0;
              bus.IF_instruction <= NOP_WORD;
            end else begin
              pc                 <= pc_next_seq;
              bus.IF_valid       <= 1'b1;
              bus.IF_instruction <= bus.IMEM_instruction;
              bus.IF_PC          <= pc;
              bus.IF_PC_plus4    <= pc_next_seq;
              if (bus.fetch_count != CNT_MAX) begin
                bus.fetch_count <= bus.fetch_count + CNT_WIDTH'(1);
              end
            end
          end
          // Otherwise decode is stalling a valid entry: everything holds
        end
        HALT: begin
          // Let a pending instruction drain, then sit idle until redirected
          if (bus.IF_ready) begin
            bus.IF_valid <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, wrap, halt and async reset.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] mem [64];
  logic [5:0]  word_idx;

  fetch_stage_if #(.PC_WIDTH(8)) bus ();

  fetch_stage #(
    .PC_WIDTH  (8),
    .RESET_PC  (8'h00),
    .NOP_WORD  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational instruction memory
  assign word_idx             = 6'(bus.IMEM_PC >> 2);
  assign bus.IMEM_instruction = mem[word_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] ins,
                        input logic [7:0] ipc, input logic [7:0] mpc, input logic [15:0] cnt);
    chk({tag, ".valid"}, 32'(bus.IF_valid), 32'(v));
    chk({tag, ".instr"}, bus.IF_instruction, ins);
    chk({tag, ".if_pc"}, 32'(bus.IF_PC), 32'(ipc));
    chk({tag, ".imem_pc"}, 32'(bus.IMEM_PC), 32'(mpc));
    chk({tag, ".count"}, 32'(bus.fetch_count), 32'(cnt));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h0000_0011;
    mem[1] = 32'h0000_0022;
    mem[2] = 32'h0000_0033;
    mem[3] = 32'h0000_0044;
    mem[4] = 32'hFFFF_FFFF;

    rst                 = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 8'h00;
    bus.IF_ready        = 1'b1;
    #1;
    // Reset state
    chk("rst.valid", 32'(bus.IF_valid), 32'h0);
    chk("rst.instr", bus.IF_instruction, 32'h0);
    chk("rst.imem_pc", 32'(bus.IMEM_PC), 32'h00);
    chk("rst.if_pc", 32'(bus.IF_PC), 32'h00);
    chk("rst.plus4", 32'(bus.IF_PC_plus4), 32'h00);
    chk("rst.halted", 32'(bus.halted), 32'h0);
    chk("rst.count", 32'(bus.fetch_count), 32'h0);

    step();
    step();
    rst = 1'b0;
    chk("rel.imem_pc", 32'(bus.IMEM_PC), 32'h00);

    // Back-to-back fetch of the first two words
    step();
    chk_if("f0", 1'b1, 32'h11, 8'h00, 8'h04, 16'd1);
    chk("f0.plus4", 32'(bus.IF_PC_plus4), 32'h04);
    step();
    chk_if("f1", 1'b1, 32'h22, 8'h04, 8'h08, 16'd2);

    // Decode stalls three cycles: IF/ID and PC hold
    bus.IF_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if("stall", 1'b1, 32'h22, 8'h04, 8'h08, 16'd2);
    end
    bus.IF_ready = 1'b1;
    step();
    chk_if("f2", 1'b1, 32'h33, 8'h08, 8'h0C, 16'd3);
    step();
    chk_if("f3", 1'b1, 32'h44, 8'h0C, 8'h10, 16'd4);
    chk("f3.plus4", 32'(bus.IF_PC_plus4), 32'h10);
    chk("f3.halted", 32'(bus.halted), 32'h0);

    // Halt word at 0x10: not forwarded, PC frozen, count unchanged
    step();
    chk_if("halt", 1'b0, 32'h0, 8'h0C, 8'h10, 16'd4);
    chk("halt.halted", 32'(bus.halted), 32'h1);
    step();
    step();
    chk_if("halt.hold", 1'b0, 32'h0, 8'h0C, 8'h10, 16'd4);
    chk("halt.hold.halted", 32'(bus.halted), 32'h1);

    // Redirect out of halt
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h00;
    step();
    bus.redirect_valid = 1'b0;
    chk("resume.halted", 32'(bus.halted), 32'h0);
    chk("resume.valid", 32'(bus.IF_valid), 32'h0);
    chk("resume.imem_pc", 32'(bus.IMEM_PC), 32'h00);
    step();
    chk_if("r0", 1'b1, 32'h11, 8'h00, 8'h04, 16'd5);
    step();
    chk_if("r1", 1'b1, 32'h22, 8'h04, 8'h08, 16'd6);

    // Redirect while stalled squashes the pending entry; low target bits dropped
    bus.IF_ready        = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h23;
    step();
    bus.redirect_valid = 1'b0;
    bus.IF_ready       = 1'b1;
    chk_if("rds", 1'b0, 32'h0, 8'h04, 8'h20, 16'd6);
    step();
    chk_if("rds.f", 1'b1, 32'hA000_0008, 8'h20, 8'h24, 16'd7);

    // Wrap from 0xFC to 0x00
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'hFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("wrap.imem_pc", 32'(bus.IMEM_PC), 32'hFC);
    chk("wrap.valid", 32'(bus.IF_valid), 32'h0);
    step();
    chk_if("wrap.fc", 1'b1, 32'hA000_003F, 8'hFC, 8'h00, 16'd8);
    chk("wrap.plus4", 32'(bus.IF_PC_plus4), 32'h00);
    step();
    chk_if("wrap.00", 1'b1, 32'h11, 8'h00, 8'h04, 16'd9);
    chk("wrap.halted", 32'(bus.halted), 32'h0);

    // Async reset between edges takes effect immediately
    #3;
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(bus.IF_valid), 32'h0);
    chk("arst.imem_pc", 32'(bus.IMEM_PC), 32'h00);
    chk("arst.count", 32'(bus.fetch_count), 32'h0);
    chk("arst.instr", bus.IF_instruction, 32'h0);
    chk("arst.if_pc", 32'(bus.IF_PC), 32'h00);

    // Redirect during reset is ignored
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h40;
    step();
    chk("rstredir.imem_pc", 32'(bus.IMEM_PC), 32'h00);
    bus.redirect_valid = 1'b0;
    rst = 1'b0;
    step();
    chk_if("post", 1'b1, 32'h11, 8'h00, 8'h04, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory's 8-bit byte address combinationally.
- Captures the returned 32-bit instruction into an IF/ID pipeline register, which decode drains with a valid/ready handshake.
- Supports redirect (branch/jump), backpressure stall, halt-word detection and a saturating fetch counter.

Parameters:
- PC_WIDTH, 8: byte-address width; matches the instruction-memory address port.
- RESET_PC, 8'h00: PC value after reset.
- NOP_WORD, 32'h00000000: value held in IF_instruction whenever the register is invalid or reset.
- HALT_WORD, 32'hFFFFFFFF: fetched word that stops fetching.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- IMEM_PC  output  PC_WIDTH  byte address to instruction memory; equals the internal pc register, combinational.
- IMEM_instruction  input  32  word returned combinationally by the instruction memory for IMEM_PC.
- redirect_valid  input  1  one-cycle request to change the PC (taken branch/jump from a later stage).
- redirect_target  input  PC_WIDTH  new byte address; bits [1:0] ignored.
- IF_ready  input  1  decode accepts the IF/ID register this cycle.
- IF_valid  output  1  IF/ID register holds a valid instruction.
- IF_instruction  output  32  captured instruction.
- IF_PC  output  PC_WIDTH  address of IF_instruction.
- IF_PC_plus4  output  PC_WIDTH  IF_PC+4, modulo 2^PC_WIDTH.
- halted  output  1  fetch stopped on HALT_WORD.
- fetch_count  output  16  number of instructions delivered into IF/ID; saturating.

Behaviour:
- Reset (async, any time, including mid-stall or mid-halt):
  - pc=RESET_PC with bits [1:0] forced to 0; state=RUN.
  - IF_valid=0, IF_instruction=NOP_WORD, IF_PC=0, IF_PC_plus4=0, halted=0, fetch_count=0.
  - Outputs take these values immediately, without waiting for a clock.
- pc[1:0] is always 00. Increment is pc+4, wrapping 8'hFC -> 8'h00 with no flag.
- States:
  - RUN: fetching.
  - HALT: pc frozen, no new captures.
- advance = (state==RUN) && (!IF_valid || IF_ready).
- Priority each cycle, highest first:
  1. redirect_valid:
     - pc <= {redirect_target[PC_WIDTH-1:2],2'b00}; IF_valid <= 0; IF_instruction <= NOP_WORD.
     - state <= RUN; halted <= 0; no capture this cycle; fetch_count unchanged.
     - Applies even if IF_valid && !IF_ready; the wrong-path instruction is squashed.
  2. advance && IMEM_instruction==HALT_WORD:
     - The halt word is not forwarded. IF_valid <= 0; IF_instruction <= NOP_WORD.
     - pc holds the halt address; state <= HALT; halted <= 1.
  3. advance (normal fetch):
     - IF_valid <= 1; IF_instruction <= IMEM_instruction; IF_PC <= pc; IF_PC_plus4 <= pc+4.
     - pc <= pc+4; fetch_count <= fetch_count+1, saturating at 16'hFFFF.
  4. RUN with IF_valid && !IF_ready (stall): all registers hold. IF outputs must be stable while valid and not ready.
  5. HALT without redirect:
     - If IF_ready, IF_valid <= 0 (a pending instruction drains normally).
     - Otherwise everything holds.
- Latency: instruction at pc appears on IF_* one clock after the cycle it is addressed. Sustained throughput is 1 instruction/cycle while IF_ready=1.
- First capture after reset release occurs on the first rising edge with rst=0.
- Redirect while rst=1 is ignored.
- IF_PC and IF_PC_plus4 keep their last values when IF_valid drops; consumers must qualify them with IF_valid.

Test Plan:
- Reset, then release with IF_ready=1; memory words 0..3 = 11,22,33,44 -> IMEM_PC 00,04,08,0C on successive cycles. IF_instruction 11,22,33,44 appear one cycle later with IF_PC 00,04,08,0C, IF_valid=1. fetch_count reaches 4.
- Stall: after 2 captures hold IF_ready=0 for 3 cycles -> IF_instruction=22, IF_PC=04 and IMEM_PC=08 all stable. On IF_ready=1, 33 appears the next cycle with no loss or duplication.
- Redirect while stalled: IF_valid=1, IF_ready=0, redirect_valid=1, target 8'h23 -> next cycle IF_valid=0, IMEM_PC=20. The following cycle IF_PC=20.
- Wrap: redirect to 8'hFC -> IF_PC=FC with IF_PC_plus4=00, then IF_PC=00. No error output.
- Halt: memory word at 0x10 = FFFFFFFF -> after the instruction at 0x0C is captured, halted=1 and IMEM_PC stays 10. IF_valid drops once 0x0C is consumed; fetch_count is unchanged by the halt. Then redirect to 0x00 -> halted=0 and fetch resumes.
- Async reset mid-stream: assert rst between clock edges while IF_valid=1 -> IF_valid=0, IMEM_PC=RESET_PC, fetch_count=0 before the next edge.
